// File: rtl/or1200_ic_biu_refill.sv
// -----------------------------------------------------------------------------
// or1200_ic_biu_refill
//
// Bus-side refill engine for the instruction cache. It turns the IC FSM's
// biu_read / burst / saved_addr request into a Wishbone B3 read cycle:
// a single classic beat for uncached or cache-inhibited fetches, or a
// LINE_BEATS-long wrapping burst for a line refill. Per-beat data, valid and
// error strobes go back to the IC FSM and the cache RAMs.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   biu_read          fetch request (level, held while the fetch is wanted)
//   burst             1 = line refill, 0 = single word (sampled at cycle start)
//   saved_addr        fetch byte address (sampled at cycle start)
//   biudata           read data to the IC (pass-through of wb_dat_i)
//   biudata_valid     one pulse per accepted beat
//   biudata_error     bus error pulse
//   wb_cyc_o..wb_bte_o  registered Wishbone master outputs
//   wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i  Wishbone slave responses
//
// Parameters:
//   LINE_BEATS  words per cache line (power of two, 2..8)
//   BTE_CODE    wb_bte_o value during bursts; must match LINE_BEATS
// -----------------------------------------------------------------------------
module or1200_ic_biu_refill #(
    parameter int         LINE_BEATS = 4,
    parameter logic [1:0] BTE_CODE   = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        biu_read,
    input  logic        burst,
    input  logic [31:0] saved_addr,
    output logic [31:0] biudata,
    output logic        biudata_valid,
    output logic        biudata_error,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i
);

    // Width of the word index inside a line; also wide enough for the
    // remaining-beats counter, which never exceeds LINE_BEATS-1.
    localparam int IDXW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

    localparam logic [IDXW-1:0] CNT_LAST = IDXW'(LINE_BEATS - 1);
    localparam logic [IDXW-1:0] CNT_ZERO = IDXW'(0);
    localparam logic [IDXW-1:0] CNT_ONE  = IDXW'(1);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_RETRY = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic        r_cyc;
    logic        r_stb;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_adr;
    logic [2:0]  r_cti;
    logic [1:0]  r_bte;
    logic [IDXW-1:0] r_cnt;

    logic        w_cyc_nxt;
    logic        w_stb_nxt;
    logic [31:0] w_adr_nxt;
    logic [2:0]  w_cti_nxt;
    logic [1:0]  w_bte_nxt;
    logic [IDXW-1:0] w_cnt_nxt;

    logic            w_in_req;
    logic [IDXW-1:0] w_idx_inc;
    logic [31:0]     w_adr_wrap;
    logic            w_unused_addr_bits;

    // The byte offset of the fetch address never reaches the bus.
    assign w_unused_addr_bits = &{1'b0, saved_addr[1:0]};

    // Next word inside the line: only the index bits advance, so the
    // address wraps at the line boundary and the upper bits stay put.
    assign w_idx_inc  = r_adr[IDXW+1:2] + CNT_ONE;
    assign w_adr_wrap = {r_adr[31:IDXW+2], w_idx_inc, 2'b00};

    // Strobes to the IC are qualified by an active request; an abort
    // (biu_read low) or a reset in progress suppresses them. Error wins
    // over a simultaneous ack.
    assign w_in_req      = (r_state == ST_REQ);
    assign biudata_error = w_in_req & biu_read & wb_err_i & ~rst;
    assign biudata_valid = w_in_req & biu_read & wb_ack_i & ~wb_err_i & ~rst;
    assign biudata       = wb_dat_i;

    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_stb;
    assign wb_we_o  = r_we;
    assign wb_sel_o = r_sel;
    assign wb_adr_o = r_adr;
    assign wb_cti_o = r_cti;
    assign wb_bte_o = r_bte;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next bus-register values.
    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        w_stb_nxt   = r_stb;
        w_adr_nxt   = r_adr;
        w_cti_nxt   = r_cti;
        w_bte_nxt   = r_bte;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (biu_read) begin
                    w_state_nxt = ST_REQ;
                    w_cyc_nxt   = 1'b1;
                    w_stb_nxt   = 1'b1;
                    w_adr_nxt   = {saved_addr[31:2], 2'b00};
                    if (burst) begin
                        w_cti_nxt = CTI_INCR;
                        w_bte_nxt = BTE_CODE;
                        w_cnt_nxt = CNT_LAST;
                    end else begin
                        w_cti_nxt = CTI_END;
                        w_bte_nxt = BTE_LINEAR;
                        w_cnt_nxt = CNT_ZERO;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_REQ: begin
                if (!biu_read || wb_err_i) begin
                    // Abort or bus error: end the cycle, abandon remaining beats.
                    w_state_nxt = ST_DONE;
                    w_cyc_nxt   = 1'b0;
                    w_stb_nxt   = 1'b0;
                    w_cti_nxt   = CTI_CLASSIC;
                    w_bte_nxt   = BTE_LINEAR;
                end else if (wb_ack_i) begin
                    if (r_cnt != CNT_ZERO) begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                        w_adr_nxt = w_adr_wrap;
                        // The beat about to be issued is the last one.
                        if (r_cnt == CNT_ONE) begin
                            w_cti_nxt = CTI_END;
                        end else begin
                            w_cti_nxt = r_cti;
                        end
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_cyc_nxt   = 1'b0;
                        w_stb_nxt   = 1'b0;
                        w_cti_nxt   = CTI_CLASSIC;
                        w_bte_nxt   = BTE_LINEAR;
                    end
                end else if (wb_rty_i) begin
                    // Hold the bus but withdraw the strobe for one cycle.
                    w_state_nxt = ST_RETRY;
                    w_stb_nxt   = 1'b0;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end

            ST_RETRY: begin
                if (!biu_read) begin
                    w_state_nxt = ST_DONE;
                    w_cyc_nxt   = 1'b0;
                    w_stb_nxt   = 1'b0;
                    w_cti_nxt   = CTI_CLASSIC;
                    w_bte_nxt   = BTE_LINEAR;
                end else begin
                    // Reissue the same beat: address, cti and counter unchanged.
                    w_state_nxt = ST_REQ;
                    w_stb_nxt   = 1'b1;
                end
            end

            ST_DONE: begin
                // Turnaround cycle; biu_read is deliberately ignored here so a
                // stale request cannot relaunch a cycle.
                w_state_nxt = ST_IDLE;
                w_cyc_nxt   = 1'b0;
                w_stb_nxt   = 1'b0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cyc_nxt   = 1'b0;
                w_stb_nxt   = 1'b0;
                w_cti_nxt   = CTI_CLASSIC;
                w_bte_nxt   = BTE_LINEAR;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Registered Wishbone outputs and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_sel <= 4'hF;
            r_adr <= 32'h0000_0000;
            r_cti <= CTI_CLASSIC;
            r_bte <= BTE_LINEAR;
            r_cnt <= CNT_ZERO;
        end else begin
            r_cyc <= w_cyc_nxt;
            r_stb <= w_stb_nxt;
            r_we  <= 1'b0;
            r_sel <= 4'hF;
            r_adr <= w_adr_nxt;
            r_cti <= w_cti_nxt;
            r_bte <= w_bte_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_or1200_ic_biu_refill.sv
module tb_or1200_ic_biu_refill;

    localparam int  LB   = 4;
    localparam byte C_W  = 8'd0;  // wait state
    localparam byte C_A  = 8'd1;  // ack
    localparam byte C_E  = 8'd2;  // err
    localparam byte C_R  = 8'd3;  // retry
    localparam byte C_AB = 8'd4;  // ack while biu_read is dropped (abort)
    localparam byte C_EA = 8'd5;  // err and ack together

    logic        clk;
    logic        rst;
    logic        biu_read;
    logic        burst;
    logic [31:0] saved_addr;
    logic [31:0] biudata;
    logic        biudata_valid;
    logic        biudata_error;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;

    int errors = 0;
    int checks = 0;

    // slave response plan, one code per strobed cycle; empty -> ack
    byte plan[$];
    logic hold_after;

    // observations gathered by the driver
    logic [31:0] ob_adr[$];
    logic [2:0]  ob_cti[$];
    logic [1:0]  ob_bte[$];
    int          ob_beat[$];
    logic [31:0] ack_adr[$];
    logic [2:0]  ack_cti[$];
    int n_valid, n_err, n_stb_low, n_static_bad, n_dat_bad, lat, gap;
    bit timeout;

    or1200_ic_biu_refill #(.LINE_BEATS(LB), .BTE_CODE(2'b01)) dut (
        .clk(clk), .rst(rst), .biu_read(biu_read), .burst(burst),
        .saved_addr(saved_addr), .biudata(biudata),
        .biudata_valid(biudata_valid), .biudata_error(biudata_error),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_cti_o(wb_cti_o),
        .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (transaction level) ----------------
    function automatic logic [31:0] exp_addr(input logic [31:0] base, input logic b, input int k);
        logic [31:0] word;
        word = base >> 2;
        if (!b) return base & 32'hFFFF_FFFC;
        return ((word - (word % LB)) + ((word + k) % LB)) << 2;
    endfunction

    function automatic logic [2:0] exp_cti(input logic b, input int k);
        if (b && k < LB - 1) return 3'b010;
        return 3'b111;
    endfunction

    function automatic void model_txn(input logic b, output int ev, output int ee, output int er);
        int beats;
        int i;
        bit done;
        byte c;
        beats = b ? LB : 1;
        ev = 0; ee = 0; er = 0; i = 0; done = 0;
        while (!done) begin
            c = (i < plan.size()) ? plan[i] : C_A;
            i++;
            case (c)
                C_A:       begin ev++; if (ev == beats) done = 1; end
                C_E, C_EA: begin ee = 1; done = 1; end
                C_R:       er++;
                C_AB:      done = 1;
                default:   ;
            endcase
        end
    endfunction

    // ---------------- driver: acts as IC FSM and Wishbone slave ----------------
    task automatic run_txn(input logic [31:0] addr, input logic b);
        int guard;
        byte code;
        ob_adr.delete(); ob_cti.delete(); ob_bte.delete(); ob_beat.delete();
        ack_adr.delete(); ack_cti.delete();
        n_valid = 0; n_err = 0; n_stb_low = 0; n_static_bad = 0; n_dat_bad = 0;
        lat = 0; gap = 0; timeout = 0;
        @(posedge clk); #1;
        biu_read = 1'b1; burst = b; saved_addr = addr;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!wb_cyc_o && lat < 8);
        if (!wb_cyc_o) timeout = 1;
        guard = 0;
        while (wb_cyc_o && guard < 200) begin
            guard++;
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
            wb_dat_i = $urandom();
            if (wb_stb_o) begin
                code = (plan.size() > 0) ? plan.pop_front() : C_A;
                ob_adr.push_back(wb_adr_o);
                ob_cti.push_back(wb_cti_o);
                ob_bte.push_back(wb_bte_o);
                ob_beat.push_back(n_valid);
                if (wb_we_o !== 1'b0 || wb_sel_o !== 4'hF) n_static_bad++;
                case (code)
                    C_A:     wb_ack_i = 1'b1;
                    C_E:     wb_err_i = 1'b1;
                    C_R:     wb_rty_i = 1'b1;
                    C_AB:    begin wb_ack_i = 1'b1; biu_read = 1'b0; end
                    C_EA:    begin wb_ack_i = 1'b1; wb_err_i = 1'b1; end
                    default: ;
                endcase
            end else begin
                n_stb_low++;
            end
            #1;
            if (biudata !== wb_dat_i) n_dat_bad++;
            if (biudata_valid === 1'b1) begin
                n_valid++;
                ack_adr.push_back(wb_adr_o);
                ack_cti.push_back(wb_cti_o);
            end
            if (biudata_error === 1'b1) n_err++;
            @(posedge clk); #1;
        end
        if (wb_cyc_o) timeout = 1;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        burst = 1'b0;
        biu_read = hold_after;
        if (hold_after) begin
            // count cycles the held request waits before a new cycle starts
            while (!wb_cyc_o && gap < 6) begin
                gap++;
                @(posedge clk); #1;
            end
            biu_read = 1'b0;
            @(posedge clk); #1;
        end
        biu_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1; biu_read = 1'b1; wb_ack_i = 1'b1; wb_err_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (biudata_valid !== 1'b0 || biudata_error !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: got %b%b expected 00", biudata_valid, biudata_error);
        end
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin
            errors++; $display("FAIL reset_cyc_stb_we: got %b expected 000", {wb_cyc_o, wb_stb_o, wb_we_o});
        end
        checks++;
        if (wb_adr_o !== 32'h0) begin
            errors++; $display("FAIL reset_adr: got %h expected 00000000", wb_adr_o);
        end
        checks++;
        if ({wb_cti_o, wb_bte_o, wb_sel_o} !== {3'b000, 2'b00, 4'hF}) begin
            errors++; $display("FAIL reset_cti_bte_sel: got %b %b %h expected 000 00 f", wb_cti_o, wb_bte_o, wb_sel_o);
        end
        rst = 1'b0; biu_read = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        plan = '{C_W, C_W, C_A};
        hold_after = 1'b1;
        run_txn(32'h0000_1006, 1'b0);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL single_latency: got %0d expected 1", lat); end
        checks++;
        if (n_valid !== 1) begin errors++; $display("FAIL single_valid_count: got %0d expected 1", n_valid); end
        checks++;
        if (ob_adr.size() !== 3) begin errors++; $display("FAIL single_stb_cycles: got %0d expected 3", ob_adr.size()); end
        foreach (ob_adr[i]) begin
            checks++;
            if (ob_adr[i] !== 32'h0000_1004 || ob_cti[i] !== 3'b111) begin
                errors++; $display("FAIL single_adr_cti[%0d]: got %h/%b expected 00001004/111", i, ob_adr[i], ob_cti[i]);
            end
        end
        checks++;
        if (gap !== 2) begin errors++; $display("FAIL single_done_gap: got %0d expected 2", gap); end
        checks++;
        if (n_dat_bad !== 0 || n_static_bad !== 0) begin
            errors++; $display("FAIL single_data_static: got %0d/%0d expected 0/0", n_dat_bad, n_static_bad);
        end
    endtask

    task automatic test_burst;
        logic [31:0] tbl_adr[4] = '{32'h2008, 32'h200C, 32'h2000, 32'h2004};
        logic [2:0]  tbl_cti[4] = '{3'b010, 3'b010, 3'b010, 3'b111};
        plan.delete();
        hold_after = 1'b0;
        run_txn(32'h0000_2008, 1'b1);
        checks++;
        if (n_valid !== 4 || ob_adr.size() !== 4) begin
            errors++; $display("FAIL burst_beats: got %0d valid %0d strobes expected 4 4", n_valid, ob_adr.size());
        end
        for (int i = 0; i < 4 && i < ack_adr.size(); i++) begin
            checks++;
            if (ack_adr[i] !== tbl_adr[i] || ack_cti[i] !== tbl_cti[i]) begin
                errors++; $display("FAIL burst_beat[%0d]: got %h/%b expected %h/%b", i, ack_adr[i], ack_cti[i], tbl_adr[i], tbl_cti[i]);
            end
        end
        foreach (ob_bte[i]) begin
            checks++;
            if (ob_bte[i] !== 2'b01) begin errors++; $display("FAIL burst_bte[%0d]: got %b expected 01", i, ob_bte[i]); end
        end
        checks++;
        if (n_err !== 0 || timeout) begin errors++; $display("FAIL burst_err_timeout: got %0d/%0d expected 0/0", n_err, timeout); end
    endtask

    task automatic test_error;
        plan = '{C_A, C_E};
        hold_after = 1'b0;
        run_txn(32'h0000_2008, 1'b1);
        checks++;
        if (n_valid !== 1 || n_err !== 1) begin
            errors++; $display("FAIL error_counts: got valid=%0d err=%0d expected 1 1", n_valid, n_err);
        end
        checks++;
        if (ob_adr.size() !== 2) begin errors++; $display("FAIL error_no_more_beats: got %0d expected 2", ob_adr.size()); end
        plan = '{C_A, C_EA};
        run_txn(32'h0000_2008, 1'b1);
        checks++;
        if (n_valid !== 1 || n_err !== 1) begin
            errors++; $display("FAIL error_with_ack: got valid=%0d err=%0d expected 1 1", n_valid, n_err);
        end
    endtask

    task automatic test_retry;
        plan = '{C_R, C_A};
        hold_after = 1'b0;
        run_txn(32'h0000_3000, 1'b0);
        checks++;
        if (n_stb_low !== 1) begin errors++; $display("FAIL retry_stb_low: got %0d expected 1", n_stb_low); end
        checks++;
        if (n_valid !== 1) begin errors++; $display("FAIL retry_valid: got %0d expected 1", n_valid); end
        checks++;
        if (ob_adr.size() !== 2) begin errors++; $display("FAIL retry_strobes: got %0d expected 2", ob_adr.size()); end
        foreach (ob_adr[i]) begin
            checks++;
            if (ob_adr[i] !== 32'h0000_3000 || ob_cti[i] !== 3'b111) begin
                errors++; $display("FAIL retry_reissue[%0d]: got %h/%b expected 00003000/111", i, ob_adr[i], ob_cti[i]);
            end
        end
    endtask

    task automatic test_abort;
        plan = '{C_A, C_AB};
        hold_after = 1'b1;
        run_txn(32'h0000_4000, 1'b1);
        checks++;
        if (n_valid !== 1 || n_err !== 0) begin
            errors++; $display("FAIL abort_counts: got valid=%0d err=%0d expected 1 0", n_valid, n_err);
        end
        checks++;
        if (ob_adr.size() !== 2) begin errors++; $display("FAIL abort_strobes: got %0d expected 2", ob_adr.size()); end
        checks++;
        if (gap !== 2) begin errors++; $display("FAIL abort_done_gap: got %0d expected 2", gap); end
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        biu_read = 1'b1; burst = 1'b1; saved_addr = 32'h0000_5000;
        @(posedge clk); #1;
        wb_ack_i = 1'b1;                      // beat 1
        @(posedge clk); #1;
        #1;
        checks++;
        if (biudata_valid !== 1'b1) begin errors++; $display("FAIL rstmid_beat2_valid: got %b expected 1", biudata_valid); end
        @(posedge clk); #1;
        rst = 1'b1;                           // beat 3, ack still high
        checks++;
        if (wb_adr_o !== 32'h0000_5008) begin errors++; $display("FAIL rstmid_beat3_adr: got %h expected 00005008", wb_adr_o); end
        #1;
        checks++;
        if (biudata_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_valid: got %b expected 0", biudata_valid); end
        @(posedge clk); #1;
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_adr_o, wb_cti_o, wb_bte_o, wb_sel_o} !== {2'b00, 32'h0, 3'b000, 2'b00, 4'hF}) begin
            errors++; $display("FAIL rstmid_outputs: got cyc=%b stb=%b adr=%h cti=%b bte=%b sel=%h expected reset values",
                               wb_cyc_o, wb_stb_o, wb_adr_o, wb_cti_o, wb_bte_o, wb_sel_o);
        end
        rst = 1'b0; wb_ack_i = 1'b0; biu_read = 1'b0; burst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        logic [31:0] addr;
        logic b;
        int len, r, ev, ee, er;
        for (int t = 0; t < 25; t++) begin
            addr = $urandom();
            b = 1'($urandom_range(0, 1));
            hold_after = 1'($urandom_range(0, 1));
            plan.delete();
            len = $urandom_range(0, 5);
            for (int j = 0; j < len; j++) begin
                r = $urandom_range(0, 19);
                if (r < 5)       plan.push_back(C_W);
                else if (r < 13) plan.push_back(C_A);
                else if (r < 16) plan.push_back(C_R);
                else if (r < 17) plan.push_back(C_E);
                else if (r < 18) plan.push_back(C_EA);
                else             plan.push_back(C_AB);
            end
            model_txn(b, ev, ee, er);
            run_txn(addr, b);
            plan.delete();
            checks++;
            if (n_valid !== ev || n_err !== ee || n_stb_low !== er) begin
                errors++; $display("FAIL rand%0d_counts: got v=%0d e=%0d r=%0d expected v=%0d e=%0d r=%0d",
                                   t, n_valid, n_err, n_stb_low, ev, ee, er);
            end
            checks++;
            if (timeout || lat !== 1 || gap !== (hold_after ? 2 : 0)) begin
                errors++; $display("FAIL rand%0d_timing: got to=%0d lat=%0d gap=%0d expected 0 1 %0d",
                                   t, timeout, lat, gap, hold_after ? 2 : 0);
            end
            checks++;
            if (n_dat_bad !== 0 || n_static_bad !== 0) begin
                errors++; $display("FAIL rand%0d_data_static: got %0d/%0d expected 0/0", t, n_dat_bad, n_static_bad);
            end
            foreach (ob_adr[i]) begin
                checks++;
                if (ob_adr[i] !== exp_addr(addr, b, ob_beat[i]) || ob_cti[i] !== exp_cti(b, ob_beat[i])
                    || ob_bte[i] !== (b ? 2'b01 : 2'b00)) begin
                    errors++; $display("FAIL rand%0d_strobe[%0d]: got %h/%b/%b expected %h/%b/%b", t, i,
                                       ob_adr[i], ob_cti[i], ob_bte[i], exp_addr(addr, b, ob_beat[i]),
                                       exp_cti(b, ob_beat[i]), b ? 2'b01 : 2'b00);
                end
            end
            foreach (ack_adr[i]) begin
                checks++;
                if (ack_adr[i] !== exp_addr(addr, b, i)) begin
                    errors++; $display("FAIL rand%0d_beat[%0d]: got %h expected %h", t, i, ack_adr[i], exp_addr(addr, b, i));
                end
            end
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; biu_read = 1'b0; burst = 1'b0; saved_addr = 32'h0;
        wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        hold_after = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_error();
        test_retry();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
